encode_pack_stage: RTL and testbench

ENCODE_PACK_STAGE -- requirements
Module: encode_pack_stage

---
 rtl/encode_pack_stage.sv | 193 +++++++++++++++++++
 tb/tb_encode_pack_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/encode_pack_stage.sv
// Two-lane code-word encoder and bit packer: selects a variable-length code per lane,
// appends both codes into a 128-bit accumulator and emits 64-bit words plus a flush residue.
module encode_pack_stage #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_word0,
    input  logic [31:0]      i_word1,
    input  logic             i_zero_match0,
    input  logic             i_zero_match1,
    input  logic             i_zero_type0,
    input  logic             i_zero_type1,
    input  logic [1:0]       i_dict_type0,
    input  logic [1:0]       i_dict_type1,
    input  logic [3:0]       i_location0,
    input  logic [3:0]       i_location1,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [63:0]      o_data,
    output logic [6:0]       o_bits,
    output logic             o_last,
    output logic [CNT_W-1:0] o_total_bits
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Returns {length[5:0], code[33:0]}; code is zero above its length.
    function automatic logic [39:0] lane_code(
        input logic [31:0] w,
        input logic        zm,
        input logic        zt,
        input logic [1:0]  dt,
        input logic [3:0]  loc
    );
        logic [39:0] res;
        if (zm) begin
            if (zt) res = {6'd2, 34'd0};
            else    res = {6'd12, 22'd0, 4'b1101, w[7:0]};
        end else begin
            case (dt)
                2'b11:   res = {6'd6, 28'd0, 2'b10, loc};
                2'b10:   res = {6'd16, 18'd0, 4'b1110, loc, w[7:0]};
                2'b01:   res = {6'd24, 10'd0, 4'b1100, loc, w[15:0]};
                default: res = {6'd34, 2'b01, w};
            endcase
        end
        return res;
    endfunction

    state_t           r_state, w_state_next;
    logic [127:0]     r_acc, w_acc_next, w_acc_sh, w_pair;
    logic [7:0]       r_cnt, w_cnt_next, w_cnt_sh;
    logic [CNT_W-1:0] r_total, w_total_next;
    logic             r_valid, r_ready, r_last;
    logic [63:0]      r_data;
    logic [6:0]       r_bits;
    logic             w_valid_next, w_ready_next, w_last_next;
    logic [63:0]      w_data_next, w_mask;
    logic [6:0]       w_bits_next, w_sum;
    logic [39:0]      w_lane0, w_lane1;
    logic             w_accept, w_emit, w_flush_go, w_full;

    // Lane codes, handshakes and next accumulator/count/state.
    always_comb begin
        w_lane0    = lane_code(i_word0, i_zero_match0, i_zero_type0, i_dict_type0, i_location0);
        w_lane1    = lane_code(i_word1, i_zero_match1, i_zero_type1, i_dict_type1, i_location1);
        w_sum      = {1'b0, w_lane0[39:34]} + {1'b0, w_lane1[39:34]};
        w_pair     = 128'(w_lane0[33:0]) | (128'(w_lane1[33:0]) << w_lane0[39:34]);
        w_accept   = i_valid & r_ready;
        w_emit     = r_valid & i_ready;
        w_flush_go = i_flush & r_ready;

        // The final flush word is handled by the state case, not as a shift.
        if (w_emit && !r_last) begin
            w_acc_sh = r_acc >> 64;
            w_cnt_sh = r_cnt - 8'd64;
        end else begin
            w_acc_sh = r_acc;
            w_cnt_sh = r_cnt;
        end

        if (w_accept) begin
            w_acc_next   = w_acc_sh | (w_pair << w_cnt_sh);
            w_cnt_next   = w_cnt_sh + {1'b0, w_sum};
            w_total_next = r_total + CNT_W'(w_sum);
        end else begin
            w_acc_next   = w_acc_sh;
            w_cnt_next   = w_cnt_sh;
            w_total_next = r_total;
        end

        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_flush_go) w_state_next = ST_FLUSH;
                else            w_state_next = ST_RUN;
            end
            ST_FLUSH: begin
                if (w_emit && r_last) begin
                    w_state_next = ST_DONE;
                    w_acc_next   = 128'd0;
                    w_cnt_next   = 8'd0;
                    w_total_next = '0;
                end else begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_DONE: w_state_next = ST_RUN;
            default: begin
                w_state_next = ST_RUN;
                w_acc_next   = 128'd0;
                w_cnt_next   = 8'd0;
                w_total_next = '0;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next-state registers.
    always_comb begin
        w_full       = (w_cnt_next >= 8'd64);
        w_mask       = (64'd1 << w_cnt_next[5:0]) - 64'd1;
        w_valid_next = 1'b0;
        w_ready_next = 1'b0;
        w_last_next  = 1'b0;
        w_data_next  = 64'd0;
        w_bits_next  = 7'd0;
        case (w_state_next)
            ST_RUN: begin
                w_ready_next = (w_cnt_next <= 8'd60);
                if (w_full) begin
                    w_valid_next = 1'b1;
                    w_data_next  = w_acc_next[63:0];
                    w_bits_next  = 7'd64;
                end else begin
                    w_valid_next = 1'b0;
                end
            end
            ST_FLUSH: begin
                w_valid_next = 1'b1;
                if (w_full) begin
                    w_data_next = w_acc_next[63:0];
                    w_bits_next = 7'd64;
                end else begin
                    w_data_next = w_acc_next[63:0] & w_mask;
                    w_bits_next = w_cnt_next[6:0];
                    w_last_next = 1'b1;
                end
            end
            default: w_valid_next = 1'b0;
        endcase
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_RUN;
            r_acc   <= 128'd0;
            r_cnt   <= 8'd0;
            r_total <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_last  <= 1'b0;
            r_data  <= 64'd0;
            r_bits  <= 7'd0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_total <= w_total_next;
            r_valid <= w_valid_next;
            r_ready <= w_ready_next;
            r_last  <= w_last_next;
            r_data  <= w_data_next;
            r_bits  <= w_bits_next;
        end
    end

    assign o_ready      = r_ready;
    assign o_valid      = r_valid;
    assign o_data       = r_data;
    assign o_bits       = r_bits;
    assign o_last       = r_last;
    assign o_total_bits = r_total;

endmodule

// File: tb/tb_encode_pack_stage.sv
// Directed self-checking bench for encode_pack_stage with hand-computed expected words.
module tb_encode_pack_stage;

    logic        i_clk = 1'b0;
    logic        i_reset, i_valid, i_flush, i_ready;
    logic [31:0] i_word0, i_word1;
    logic        i_zero_match0, i_zero_match1, i_zero_type0, i_zero_type1;
    logic [1:0]  i_dict_type0, i_dict_type1;
    logic [3:0]  i_location0, i_location1;
    logic        o_ready, o_valid, o_last;
    logic [63:0] o_data;
    logic [6:0]  o_bits;
    logic [31:0] o_total_bits;

    int checks = 0;
    int failures = 0;

    encode_pack_stage #(.CNT_W(32)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_word0(i_word0), .i_word1(i_word1),
        .i_zero_match0(i_zero_match0), .i_zero_match1(i_zero_match1),
        .i_zero_type0(i_zero_type0), .i_zero_type1(i_zero_type1),
        .i_dict_type0(i_dict_type0), .i_dict_type1(i_dict_type1),
        .i_location0(i_location0), .i_location1(i_location1),
        .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_bits(o_bits), .o_last(o_last), .o_total_bits(o_total_bits)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_pair(input logic [31:0] w0, input logic zm0, input logic zt0,
                            input logic [1:0] dt0, input logic [3:0] l0,
                            input logic [31:0] w1, input logic zm1, input logic zt1,
                            input logic [1:0] dt1, input logic [3:0] l1);
        i_word0 = w0; i_zero_match0 = zm0; i_zero_type0 = zt0; i_dict_type0 = dt0; i_location0 = l0;
        i_word1 = w1; i_zero_match1 = zm1; i_zero_type1 = zt1; i_dict_type1 = dt1; i_location1 = l1;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
    endtask

    task automatic do_flush();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
    endtask

    logic [33:0]   lane;
    logic [63:0]   exp_w;
    logic [1023:0] ref_s, got_s;
    int            ref_n, got_n, sent;
    logic [31:0]   w0, w1;

    initial begin
        i_reset = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        i_word0 = 32'd0; i_word1 = 32'd0;
        i_zero_match0 = 1'b0; i_zero_match1 = 1'b0; i_zero_type0 = 1'b0; i_zero_type1 = 1'b0;
        i_dict_type0 = 2'd0; i_dict_type1 = 2'd0; i_location0 = 4'd0; i_location1 = 4'd0;
        step(); step(); step();
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_bits", o_bits, 7'd0);
        chk("rst_last", o_last, 1'b0);
        chk("rst_total", o_total_bits, 32'd0);
        i_reset = 1'b1;
        step();
        chk("rel_ready", o_ready, 1'b1);

        // Two mmmm lanes, loc 5
        set_pair(32'h0, 1'b0, 1'b0, 2'b11, 4'd5, 32'h0, 1'b0, 1'b0, 2'b11, 4'd5);
        chk("mmmm_total", o_total_bits, 32'd12);
        chk("mmmm_novalid", o_valid, 1'b0);
        do_flush();
        chk("mmmm_valid", o_valid, 1'b1);
        chk("mmmm_data", o_data, 64'h965);
        chk("mmmm_bits", o_bits, 7'd12);
        chk("mmmm_last", o_last, 1'b1);
        step();
        chk("done_valid", o_valid, 1'b0);
        chk("done_ready", o_ready, 1'b0);
        step();
        chk("run_ready", o_ready, 1'b1);
        chk("run_total", o_total_bits, 32'd0);

        // Two zzzz lanes
        set_pair(32'h0, 1'b1, 1'b1, 2'b00, 4'd0, 32'h0, 1'b1, 1'b1, 2'b00, 4'd0);
        chk("zz_total", o_total_bits, 32'd4);
        do_flush();
        chk("zz_data", o_data, 64'd0);
        chk("zz_bits", o_bits, 7'd4);
        chk("zz_last", o_last, 1'b1);
        step(); step();
        chk("zz_total0", o_total_bits, 32'd0);
        chk("zz_ready", o_ready, 1'b1);

        // zzzx lane 0, mmxx lane 1
        set_pair(32'h000000AB, 1'b1, 1'b0, 2'b00, 4'd0, 32'h12345678, 1'b0, 1'b0, 2'b01, 4'd3);
        do_flush();
        chk("zx_mx_data", o_data, 64'hC35678DAB);
        chk("zx_mx_bits", o_bits, 7'd36);
        step(); step();

        // mmmx lane 0; zero match beats mmmm on lane 1
        set_pair(32'h1111113C, 1'b0, 1'b0, 2'b10, 4'hA, 32'hFFFFFFFF, 1'b1, 1'b1, 2'b11, 4'hF);
        do_flush();
        chk("mx_prio_data", o_data, 64'hEA3C);
        chk("mx_prio_bits", o_bits, 7'd18);
        step(); step();

        // Uncompressed pair with backpressure
        i_ready = 1'b0;
        set_pair(32'hDEADBEEF, 1'b0, 1'b0, 2'b00, 4'd0, 32'hDEADBEEF, 1'b0, 1'b0, 2'b00, 4'd0);
        lane  = 34'h1DEADBEEF;
        exp_w = {lane[29:0], lane};
        chk("unc_valid", o_valid, 1'b1);
        chk("unc_ready", o_ready, 1'b0);
        chk("unc_lane0", o_data[33:0], 34'h1DEADBEEF);
        chk("unc_total", o_total_bits, 32'd68);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("unc_hold", {o_valid, o_bits, o_data}, {1'b1, 7'd64, exp_w});
        end
        i_ready = 1'b1;
        step();
        chk("unc_after_valid", o_valid, 1'b0);
        chk("unc_after_ready", o_ready, 1'b1);
        do_flush();
        chk("unc_res", {o_last, o_bits, o_data}, {1'b1, 7'd4, 64'h7});
        step(); step();

        // Flush with nothing buffered
        do_flush();
        chk("empty_flush", {o_valid, o_last, o_bits, o_data}, {1'b1, 1'b1, 7'd0, 64'd0});
        step(); step();

        // Continuous uncompressed stream
        ref_s = '0; got_s = '0; ref_n = 0; got_n = 0; sent = 0;
        i_zero_match0 = 1'b0; i_zero_match1 = 1'b0; i_dict_type0 = 2'b00; i_dict_type1 = 2'b00;
        for (int cyc = 0; cyc < 100 && (sent < 8 || o_valid); cyc++) begin
            if (o_valid && i_ready) begin
                got_s = got_s | (1024'(o_data) << got_n);
                got_n = got_n + int'(o_bits);
            end
            if (sent < 8 && o_ready) begin
                w0 = 32'h9E3779B9 * (sent + 1);
                w1 = ~w0 ^ 32'h13579BDF;
                i_word0 = w0; i_word1 = w1; i_valid = 1'b1;
                ref_s = ref_s | (1024'({2'b01, w0}) << ref_n);
                ref_s = ref_s | (1024'({2'b01, w1}) << (ref_n + 34));
                ref_n = ref_n + 68;
                sent++;
            end else begin
                i_valid = 1'b0;
            end
            step();
        end
        i_valid = 1'b0;
        chk("stream_total", o_total_bits, 32'd544);
        chk("stream_words", got_n, 512);
        do_flush();
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (o_valid) begin
                got_s = got_s | (1024'(o_data) << got_n);
                got_n = got_n + int'(o_bits);
                if (o_last) begin
                    step();
                    break;
                end
            end
            step();
        end
        chk("stream_bits", got_n, ref_n);
        chk("stream_data", got_s, ref_s);
        step();

        // Reset during flush with 40 bits buffered
        i_ready = 1'b0;
        set_pair(32'hCAFEF00D, 1'b0, 1'b0, 2'b00, 4'd0, 32'h0, 1'b0, 1'b0, 2'b11, 4'd1);
        do_flush();
        chk("mid_bits", o_bits, 7'd40);
        chk("mid_data", o_data, (64'h21 << 34) | 64'h1CAFEF00D);
        i_reset = 1'b0;
        step();
        chk("mid_rst_outs", {o_valid, o_last, o_bits, o_data, o_total_bits},
            {1'b0, 1'b0, 7'd0, 64'd0, 32'd0});
        i_reset = 1'b1;
        i_ready = 1'b1;
        step();
        chk("post_rst_ready", o_ready, 1'b1);
        chk("post_rst_valid", o_valid, 1'b0);
        step();
        chk("post_rst_valid2", o_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
